// File: rtl/pe_col_pkg.sv
// Shared definitions for the PE column datapath.
//   PSUM_W  : width of a partial sum shifted out of the PE chain
//   ACT_W   : width of a requantized activation
//   SHIFT_W : width of the requant right-shift amount
//   requant : round-half-up shift, saturate to ACT_W, optional ReLU
package pe_col_pkg;

  localparam int PSUM_W  = 16;
  localparam int ACT_W   = 8;
  localparam int SHIFT_W = 4;

  // One guard bit is enough: the largest rounding term (1<<14) added to
  // the largest positive psum still fits in 17 signed bits.
  localparam int REQ_W = PSUM_W + 1;

  localparam logic signed [REQ_W-1:0] SAT_HI = REQ_W'((1 << (ACT_W - 1)) - 1);
  localparam logic signed [REQ_W-1:0] SAT_LO = REQ_W'(-(1 << (ACT_W - 1)));

  typedef logic signed [PSUM_W-1:0] psumT;
  typedef logic signed [ACT_W-1:0]  actT;

  function automatic actT requant(input psumT x, input logic [SHIFT_W-1:0] sh,
                                  input logic relu);
    logic signed [REQ_W-1:0] xExt;
    logic signed [REQ_W-1:0] rnd;
    logic signed [REQ_W-1:0] sum;
    logic signed [REQ_W-1:0] shifted;
    actT res;
    xExt = {x[PSUM_W-1], x};
    rnd  = '0;
    if (sh != '0) begin
      rnd = REQ_W'(1) << (sh - SHIFT_W'(1));
    end
    sum     = xExt + rnd;
    shifted = sum >>> sh;
    if (shifted > SAT_HI) begin
      res = SAT_HI[ACT_W-1:0];
    end else if (shifted < SAT_LO) begin
      res = SAT_LO[ACT_W-1:0];
    end else begin
      res = shifted[ACT_W-1:0];
    end
    if (relu && res[ACT_W-1]) begin
      res = '0;
    end
    return res;
  endfunction

endpackage

// File: rtl/pe_result_collector_sync_fifo.sv
// Synchronous show-ahead FIFO.
//   clk_cal / rst_cal : clock, synchronous active-high reset
//   flush             : synchronous empty, same effect as reset
//   push / din        : write request and data (accepted if not full, or
//                       if a pop happens in the same cycle)
//   pop               : read request (ignored while empty)
//   dout              : head entry, zero while empty
//   full / empty      : occupancy status
module pe_result_collector_sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16
) (
  input  logic             clk_cal,
  input  logic             rst_cal,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtrReg;
  logic [PTR_W-1:0] rdPtrReg;
  logic [CNT_W-1:0] countReg;
  logic             popEff;
  logic             pushEff;

  assign full  = (countReg == CNT_W'(DEPTH));
  assign empty = (countReg == '0);

  // A pop frees a slot in the same edge, so a push into a full FIFO
  // still succeeds when it is paired with a pop.
  assign popEff  = pop & ~empty;
  assign pushEff = push & (~full | popEff);

  // Head is read straight from the array; a write to an empty FIFO
  // becomes visible only after the writing edge (no fall-through).
  assign dout = empty ? '0 : mem[rdPtrReg];

  always_ff @(posedge clk_cal) begin
    if (pushEff) begin
      mem[wrPtrReg] <= din;
    end
  end

  always_ff @(posedge clk_cal) begin
    if (rst_cal || flush) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else begin
      if (pushEff) begin
        wrPtrReg <= wrPtrReg + PTR_W'(1);
      end
      if (popEff) begin
        rdPtrReg <= rdPtrReg + PTR_W'(1);
      end
      case ({pushEff, popEff})
        2'b10:   countReg <= countReg + CNT_W'(1);
        2'b01:   countReg <= countReg - CNT_W'(1);
        default: countReg <= countReg;
      endcase
    end
  end

endmodule

// File: rtl/pe_result_collector.sv
// Result sink at the top of a systolic PE column.
// Captures each burst of PE_NUM partial sums, requantizes them to signed
// activations tagged with their PE index and buffers them in a FIFO that
// drains over valid/ready. The PE chain cannot stall, so a full FIFO drops
// entries and raises a sticky overflow flag instead.
//   clk_cal, rst_cal      : clock, synchronous active-high reset
//   IOMap, IOMapVld       : incoming psum word and its valid
//   Shift, ReluEn         : requant controls, static during a burst
//   Clear                 : synchronous flush, same effect as reset
//   IDataRdy              : downstream ready
//   OData, OIdx, ODataVld : FIFO head (activation, PE index) and non-empty
//   ORowDone              : pulse when the last entry of an intact burst is written
//   OOverflow, OBurstErr  : sticky drop / short-burst flags
module pe_result_collector
  import pe_col_pkg::*;
#(
  parameter int PE_NUM     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                      clk_cal,
  input  logic                      rst_cal,
  input  logic [PSUM_W-1:0]         IOMap,
  input  logic                      IOMapVld,
  input  logic [SHIFT_W-1:0]        Shift,
  input  logic                      ReluEn,
  input  logic                      Clear,
  input  logic                      IDataRdy,
  output logic [ACT_W-1:0]          OData,
  output logic [$clog2(PE_NUM)-1:0] OIdx,
  output logic                      ODataVld,
  output logic                      ORowDone,
  output logic                      OOverflow,
  output logic                      OBurstErr
);

  localparam int IDX_W   = $clog2(PE_NUM);
  localparam int ENTRY_W = IDX_W + ACT_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PE_NUM - 1);

  logic syncRst;

  // Burst counter and stage-1 capture registers
  logic [IDX_W-1:0]   cntReg;
  logic               s1VldReg;
  psumT               s1DataReg;
  logic [IDX_W-1:0]   s1IdxReg;
  logic               s1LastReg;
  logic [SHIFT_W-1:0] s1ShiftReg;
  logic               s1ReluReg;

  // Flags
  logic dropAccReg;
  logic rowDoneReg;
  logic overflowReg;
  logic burstErrReg;

  // Stage 2 / FIFO interface
  actT                s2Act;
  logic [ENTRY_W-1:0] fifoDin;
  logic [ENTRY_W-1:0] fifoDout;
  logic               fifoFull;
  logic               fifoEmpty;
  logic               popReq;
  logic               pushOk;
  logic               dropNow;
  logic               burstDropped;

  assign syncRst = rst_cal | Clear;

  assign s2Act   = requant(s1DataReg, s1ShiftReg, s1ReluReg);
  assign fifoDin = {s1IdxReg, s2Act};

  assign popReq  = ~fifoEmpty & IDataRdy;
  assign pushOk  = s1VldReg & (~fifoFull | popReq);
  assign dropNow = s1VldReg & fifoFull & ~popReq;

  // Has any entry of the burst currently in stage 2 been dropped? Index 0
  // starts a fresh burst, so the accumulated history is ignored there.
  assign burstDropped = dropNow | ((s1IdxReg != '0) & dropAccReg);

  always_ff @(posedge clk_cal) begin
    if (syncRst) begin
      cntReg      <= '0;
      s1VldReg    <= 1'b0;
      s1DataReg   <= '0;
      s1IdxReg    <= '0;
      s1LastReg   <= 1'b0;
      s1ShiftReg  <= '0;
      s1ReluReg   <= 1'b0;
      dropAccReg  <= 1'b0;
      rowDoneReg  <= 1'b0;
      overflowReg <= 1'b0;
      burstErrReg <= 1'b0;
    end else begin
      s1VldReg <= IOMapVld;
      if (IOMapVld) begin
        s1DataReg  <= IOMap;
        s1IdxReg   <= cntReg;
        s1LastReg  <= (cntReg == LAST_IDX);
        // Requant controls travel with the word so a change right after
        // the burst cannot affect its last entry.
        s1ShiftReg <= Shift;
        s1ReluReg  <= ReluEn;
        cntReg     <= (cntReg == LAST_IDX) ? '0 : cntReg + IDX_W'(1);
      end else if (cntReg != '0) begin
        // Valid fell mid-burst: keep what was captured, restart indexing.
        burstErrReg <= 1'b1;
        cntReg      <= '0;
      end

      if (s1VldReg) begin
        dropAccReg <= s1LastReg ? 1'b0 : burstDropped;
      end
      rowDoneReg <= s1VldReg & s1LastReg & pushOk & ~burstDropped;
      if (dropNow) begin
        overflowReg <= 1'b1;
      end
    end
  end

  pe_result_collector_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_sync_fifo (
    .clk_cal (clk_cal),
    .rst_cal (rst_cal),
    .flush   (Clear),
    .push    (s1VldReg),
    .pop     (popReq),
    .din     (fifoDin),
    .dout    (fifoDout),
    .full    (fifoFull),
    .empty   (fifoEmpty)
  );

  assign OData     = fifoDout[ACT_W-1:0];
  assign OIdx      = fifoDout[ENTRY_W-1:ACT_W];
  assign ODataVld  = ~fifoEmpty;
  assign ORowDone  = rowDoneReg;
  assign OOverflow = overflowReg;
  assign OBurstErr = burstErrReg;

endmodule

// File: doc/pe_result_collector.md
# pe_result_collector

Sink at the top of a systolic PE column. It captures the per-channel result burst that the column shifts upward as 16-bit partial sums. Each result is requantized to a signed 8-bit activation, with optional ReLU, and tagged with its PE index. Results are buffered in a FIFO and drained over a valid/ready handshake toward the output feature-map buffer, because the PE chain cannot be back-pressured.

## Interface
- PE_NUM, 8, PEs per column; equals the burst length (≥2)
- FIFO_DEPTH, 16, entries in the output FIFO (power of two, ≥ PE_NUM)
- clk_cal  in  1  compute clock; all logic on rising edge
- rst_cal  in  1  reset, synchronous, active-high
- IOMap  in  16  result word from the top PE, two's complement
- IOMapVld  in  1  result valid; high for PE_NUM consecutive cycles per burst
- Shift  in  4  requant right-shift amount, 0–15; static during a burst
- ReluEn  in  1  clamp negative results to 0; static during a burst
- Clear  in  1  synchronous flush; same effect as rst_cal
- IDataRdy  in  1  downstream ready
- OData  out  8  requantized activation, signed
- OIdx  out  $clog2(PE_NUM)  PE index of OData (0 = top PE)
- ODataVld  out  1  FIFO non-empty
- ORowDone  out  1  one-cycle pulse: the last element of a complete burst entered the FIFO
- OOverflow  out  1  sticky: an entry was dropped because the FIFO was full
- OBurstErr  out  1  sticky: IOMapVld fell before PE_NUM words arrived

## Operation
- **Stage 1 (capture).** On each cycle with IOMapVld=1, register IOMap with index cnt. Then cnt increments, wrapping PE_NUM-1→0. Mark the capture "last" when cnt = PE_NUM-1.
- **Burst error.** If IOMapVld=0 while cnt≠0:
  - set OBurstErr;
  - reset cnt to 0;
  - keep already-captured entries.
- **Stage 2 (requant + write).** Requantize the stage-1 word and push {idx, data} into the FIFO.
- **Requant arithmetic.** Performed at 17 bits signed; no intermediate overflow is permitted.
  - r = (x + (Shift>0 ? 1<<(Shift-1) : 0)) >>> Shift, arithmetic shift (round half toward +∞).
  - Saturate r to [-128, 127].
  - If ReluEn=1 and r<0, r = 0.
- **FIFO.**
  - Push only when the stage-2 entry is valid.
  - Pop when ODataVld & IDataRdy.
  - Full with no pop: the incoming entry is dropped, OOverflow is set, and ORowDone is suppressed for that burst.
  - Full with a simultaneous pop: the push succeeds.
  - Empty with a simultaneous push: no fall-through; data appears the next cycle.
- **ORowDone.** Pulses only when a "last" entry is actually written and no entry of that burst was dropped.
- **Reset / Clear.** Empty the FIFO, zero cnt and both pipeline valids, clear sticky flags. An in-flight burst is discarded, and the next IOMapVld is treated as index 0.
  - Output reset values: OData=0, OIdx=0, ODataVld=0, ORowDone=0, OOverflow=0, OBurstErr=0.

## Timing
- **Latency.** IOMapVld sampled at edge t → stage 1 valid after t → FIFO write at edge t+1 → ODataVld=1 from cycle t+2 if the FIFO was empty. Input-to-output latency is 2 cycles.
- **ORowDone.** High during the single cycle after the edge that writes the last entry, i.e. the same cycle that entry first becomes visible in the FIFO.
- **Throughput.** One result per cycle sustained; back-to-back bursts need no idle cycle.
- **Output stability.** OData/OIdx hold while ODataVld=1 and IDataRdy=0.
- **Sticky flags.** Assert the cycle after the causing edge; clear only on reset or Clear.
- **Clear priority.** Clear takes precedence over a simultaneous push or pop.

## Structure
- Shared package `pe_col_pkg`:
  - PSUM_W=16, ACT_W=8, SHIFT_W=4;
  - requant function (round, saturate, ReLU), shared with the future bias/requant path.
- Sub-module `u_sync_fifo`: parameterized width and depth; push, pop, full, empty; synchronous active-high reset and flush.
- Top level contains the burst counter, the two pipeline stages and the flag logic.

## Test plan
1. **Reset.** Assert rst_cal mid-burst with Shift=0 → all outputs 0; the next burst's first OIdx is 0.
2. **Nominal burst.** PE_NUM=8, IOMap=0x0100..0x0800 (step 0x100), Shift=4, ReLU off, IDataRdy=1:
   - OData = 16, 32, …, 127 (0x0800>>4 = 128 saturates), OIdx 0..7;
   - ORowDone pulses once, 2 cycles after the last input.
3. **Rounding and saturation.**
   - Shift=0: 0x7FFF → 127, 0x8000 → -128.
   - Shift=4: 24 → 2, -24 → -1, -40 → -2.
   - ReluEn=1, Shift=0: -200 → 0.
4. **Backpressure.** IDataRdy=0, two bursts (16 entries) → no overflow, ODataVld stays high. A third burst → OOverflow=1, all its entries dropped, no ORowDone. Then drain with IDataRdy=1 → the 16 entries come out in order.
5. **Short burst.** IOMapVld high for 3 cycles then low → OBurstErr=1, 3 entries delivered, no ORowDone. The next full burst yields OIdx 0..7 and ORowDone.
6. **Clear with full FIFO.** Clear while the FIFO is full and IDataRdy toggles → ODataVld=0 the next cycle, flags cleared, subsequent burst delivered normally.
